// File: rtl/note_associator.sv
// note_associator: tracks up to 12 persistent notes across peak-finder frames.
//
// On start, the 12 peak slots of new_peaks_i are matched one per cycle (MATCH, 12 cycles)
// against the working notes by circular position distance. Matched notes take the peak's
// position and the mean of the two amplitudes. Unmatched notes are then dropped. Unmatched
// peaks are placed into the lowest free slots (PLACE, 12 cycles). In DONE the working list
// is copied to out_notes_o and finished_o pulses. Latency is 25 edges from the start edge.
//
// Note word layout: {position[N-1:0], amplitude[N-1:0], valid}.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   start_i      one-cycle request, sampled only when idle
//   new_peaks_i  12 peak slots, held stable from start until finished
//   out_notes_o  registered note list, changes only on the DONE edge or reset
//   finished_o   one-cycle pulse when out_notes_o has just been updated
//
// Optional macro NOTE_DECAY_EN: unmatched notes are halved in amplitude instead of dropped,
// and only invalidated when the halved amplitude falls below 256.
module note_associator #(
    parameter int unsigned N       = 16,
    parameter int unsigned FPF     = 10,
    parameter int unsigned BPO     = 24,
    parameter int unsigned ASSDIST = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [11:0][2*N:0]  new_peaks_i,
    output logic [11:0][2*N:0]  out_notes_o,
    output logic                finished_o
);

    localparam logic [N-1:0] Wrap = N'(BPO << FPF);
    localparam logic [N-1:0] Half = Wrap >> 1;
    localparam logic [N-1:0] Dist = N'(ASSDIST);

    typedef enum logic [1:0] {StIdle, StMatch, StPlace, StDone} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    logic [11:0][N-1:0]      pos_q, pos_d;
    logic [11:0][N-1:0]      amp_q, amp_d;
    logic [11:0]             vld_q, vld_d;
    logic [11:0]             claimed_q, claimed_d;
    logic [11:0]             consumed_q, consumed_d;
    logic [11:0][2*N:0]      out_q, out_d;
    logic                    fin_q, fin_d;

    logic [N-1:0]            peak_pos, peak_amp;
    logic                    peak_vld;
    logic [N-1:0]            d;
    logic [N-1:0]            best_d;
    logic [3:0]              best_idx;
    logic                    found;
    logic [3:0]              free_idx;
    logic                    free_found;
    logic [N:0]              amp_sum;

    assign peak_pos = new_peaks_i[idx_q][2*N:N+1];
    assign peak_amp = new_peaks_i[idx_q][N:1];
    assign peak_vld = new_peaks_i[idx_q][0];

    // Nearest valid unclaimed note within Dist; strict '<' keeps the lowest index on ties.
    always_comb begin
        found    = 1'b0;
        best_idx = '0;
        best_d   = '0;
        d        = '0;
        for (int j = 0; j < 12; j++) begin
            if (vld_q[j] && !claimed_q[j]) begin
                d = (peak_pos >= pos_q[j]) ? (peak_pos - pos_q[j]) : (pos_q[j] - peak_pos);
                if (d > Half) begin
                    d = Wrap - d;
                end
                if ((d <= Dist) && (!found || (d < best_d))) begin
                    found    = 1'b1;
                    best_idx = 4'(j);
                    best_d   = d;
                end
            end
        end
    end

    // Lowest-index invalid slot; scanning downward leaves the lowest one selected.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int j = 11; j >= 0; j--) begin
            if (!vld_q[j]) begin
                free_found = 1'b1;
                free_idx   = 4'(j);
            end
        end
    end

    assign amp_sum = {1'b0, amp_q[best_idx]} + {1'b0, peak_amp};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pos_d      = pos_q;
        amp_d      = amp_q;
        vld_d      = vld_q;
        claimed_d  = claimed_q;
        consumed_d = consumed_q;
        out_d      = out_q;
        fin_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StMatch;
                    idx_d      = '0;
                    claimed_d  = '0;
                    consumed_d = '0;
                end
            end
            StMatch: begin
                if (peak_vld && found) begin
                    pos_d[best_idx]     = peak_pos;
                    amp_d[best_idx]     = amp_sum[N:1];
                    claimed_d[best_idx] = 1'b1;
                    consumed_d[idx_q]   = 1'b1;
                end
                if (idx_q == 4'd11) begin
                    // claimed_d so that a note matched by the last peak survives
                    for (int j = 0; j < 12; j++) begin
                        if (vld_q[j] && !claimed_d[j]) begin
`ifdef NOTE_DECAY_EN
                            amp_d[j] = amp_q[j] >> 1;
                            if (amp_d[j] < N'(256)) begin
                                vld_d[j] = 1'b0;
                            end
`else
                            vld_d[j] = 1'b0;
`endif
                        end
                    end
                    state_d = StPlace;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StPlace: begin
                if (peak_vld && !consumed_q[idx_q] && free_found) begin
                    pos_d[free_idx] = peak_pos;
                    amp_d[free_idx] = peak_amp;
                    vld_d[free_idx] = 1'b1;
                end
                if (idx_q == 4'd11) begin
                    state_d = StDone;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StDone: begin
                for (int j = 0; j < 12; j++) begin
                    out_d[j] = {pos_q[j], amp_q[j], vld_q[j]};
                end
                fin_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            pos_q      <= '0;
            amp_q      <= '0;
            vld_q      <= '0;
            claimed_q  <= '0;
            consumed_q <= '0;
            out_q      <= '0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            amp_q      <= amp_d;
            vld_q      <= vld_d;
            claimed_q  <= claimed_d;
            consumed_q <= consumed_d;
            out_q      <= out_d;
            fin_q      <= fin_d;
        end
    end

    assign out_notes_o = out_q;
    assign finished_o  = fin_q;

endmodule

// File: tb/tb_note_associator.sv
// Directed bench for note_associator. Positions are bins * 1024 rounded.
module tb_note_associator;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [11:0][32:0] new_peaks_i;
    logic [11:0][32:0] out_notes_o;
    logic              finished_o;

    int tests = 0;
    int fails = 0;
    int lat;
    int extra;

    note_associator dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .new_peaks_i (new_peaks_i),
        .out_notes_o (out_notes_o),
        .finished_o  (finished_o)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] mk(input int p, input int a);
        return {16'(p), 16'(a), 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_slot(input int s, input bit v, input int p, input int a);
        chk($sformatf("slot%0d.valid", s), 33'(out_notes_o[s][0]), 33'(v));
        if (v) begin
            chk($sformatf("slot%0d.pos", s), 33'(out_notes_o[s][32:17]), 33'(p));
            chk($sformatf("slot%0d.amp", s), 33'(out_notes_o[s][16:1]), 33'(a));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        tests++;
        assert (out_notes_o === '0) else begin
            fails++;
            $error("FAIL %s: got %h expected all zero", tag, out_notes_o);
        end
    endtask

    // Start pulse, then count edges to finished; a second start is injected while busy
    // when busy_start is set.
    task automatic run_frame(input bit busy_start, output int n);
        n = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        while (n < 40 && !finished_o) begin
            @(posedge clk);
            #1;
            n++;
            start_i = (busy_start && n == 3);
        end
        start_i = 1'b0;
        chk("latency", 33'(n), 33'd25);
        chk("finished_pulse", 33'(finished_o), 33'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_frame2();
        chk_slot(0, 1, 555, 10000);
        chk_slot(1, 1, 7148, 12500);
`ifdef NOTE_DECAY_EN
        chk_slot(2, 1, 8212, 10000);
        chk_slot(3, 1, 11776, 15000);
        chk_slot(4, 1, 24545, 11776);
        chk_slot(5, 1, 9428, 20000);
        chk_slot(6, 1, 17395, 18888);
        for (int s = 7; s < 12; s++) chk_slot(s, 0, 0, 0);
`else
        chk_slot(2, 1, 9428, 20000);
        chk_slot(3, 1, 17395, 18888);
        chk_slot(4, 1, 24545, 11776);
        for (int s = 5; s < 12; s++) chk_slot(s, 0, 0, 0);
`endif
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        new_peaks_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and idle behaviour
        chk_all_zero("reset_out");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("idle_finished", 33'(finished_o), 33'd0);
        end
        chk_all_zero("idle_out");

        // Frame 1: five peaks land in slots 0..4; an invalid slot carries garbage fields
        new_peaks_i     = '0;
        new_peaks_i[0]  = mk(555, 10000);
        new_peaks_i[1]  = {16'd600, 16'd9999, 1'b0};
        new_peaks_i[3]  = mk(7282, 10000);
        new_peaks_i[4]  = mk(8212, 20000);
        new_peaks_i[5]  = mk(11776, 30000);
        new_peaks_i[11] = mk(24545, 15775);
        run_frame(1'b0, lat);
        chk_slot(0, 1, 555, 10000);
        chk_slot(1, 1, 7282, 10000);
        chk_slot(2, 1, 8212, 20000);
        chk_slot(3, 1, 11776, 30000);
        chk_slot(4, 1, 24545, 15775);
        for (int s = 5; s < 12; s++) chk_slot(s, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("finished_one_cycle", 33'(finished_o), 33'd0);

        // Frame 2: match, average, drop (or decay) and place
        new_peaks_i     = '0;
        new_peaks_i[0]  = mk(555, 10000);
        new_peaks_i[3]  = mk(7148, 15000);
        new_peaks_i[4]  = mk(9428, 20000);
        new_peaks_i[8]  = mk(17395, 18888);
        new_peaks_i[11] = mk(24545, 7777);
        run_frame(1'b0, lat);
        chk_frame2();

        // Hold: changed inputs without start leave outputs alone
        new_peaks_i    = '0;
        new_peaks_i[2] = mk(3000, 4000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_finished", 33'(finished_o), 33'd0);
        end
        chk_frame2();

        // Reset mid-operation discards everything
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        do_reset();
        repeat (30) begin
            @(posedge clk);
            #1;
            if (finished_o) extra++;
        end
        chk("midop_reset_no_finish", 33'(extra), 33'd0);
        chk_all_zero("midop_reset_out");

        // Wrap-around match, with a start pulse injected while busy
        new_peaks_i    = '0;
        new_peaks_i[0] = mk(24474, 1000);
        run_frame(1'b0, lat);
        chk_slot(0, 1, 24474, 1000);
        new_peaks_i[0] = mk(102, 3000);
        run_frame(1'b1, lat);
        chk_slot(0, 1, 102, 2000);
        chk_slot(1, 0, 0, 0);
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (finished_o) extra++;
        end
        chk("busy_start_ignored", 33'(extra), 33'd0);

        // d = 0.572 bin across the wrap must not associate
        do_reset();
        new_peaks_i[0] = mk(24545, 5000);
        run_frame(1'b0, lat);
        new_peaks_i[0] = mk(555, 7000);
        run_frame(1'b0, lat);
`ifdef NOTE_DECAY_EN
        chk_slot(0, 1, 24545, 2500);
        chk_slot(1, 1, 555, 7000);
`else
        chk_slot(0, 1, 555, 7000);
        chk_slot(1, 0, 0, 0);
`endif

        // Exactly ASSDIST away still associates
        new_peaks_i[0] = mk(1067, 1000);
        run_frame(1'b0, lat);
`ifdef NOTE_DECAY_EN
        chk_slot(0, 1, 24545, 1250);
        chk_slot(1, 1, 1067, 4000);
        chk_slot(2, 0, 0, 0);
`else
        chk_slot(0, 1, 1067, 4000);
        chk_slot(1, 0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
